// File: rtl/laser_cover_scorer_pkg.sv
// laser_pkg: shared frame geometry, radius and FSM state encoding for the cover scorer.
package laser_pkg;
  localparam int NPTS = 40;
  localparam int CW = 4;
  localparam int R = 4;
  localparam int R2 = R * R;
  localparam int SW = $clog2(NPTS + 1);
  localparam int IW = $clog2(NPTS);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, EVAL, REPORT} state_t;
endpackage

// File: rtl/laser_cover_scorer_if.sv
// laser_cover_scorer_if: point stream, optimiser result and score report bundle.
interface laser_cover_scorer_if;
  import laser_pkg::*;
  logic pt_valid;
  logic [CW-1:0] x, y;
  logic done;
  logic [CW-1:0] c1x, c1y, c2x, c2y;
  logic [SW-1:0] score, hit1;
  logic score_valid, busy;
  modport master(output pt_valid, x, y, done, c1x, c1y, c2x, c2y, input score, hit1, score_valid, busy);
  modport slave(input pt_valid, x, y, done, c1x, c1y, c2x, c2y, output score, hit1, score_valid, busy);
endinterface

// File: rtl/laser_cover_scorer_in_circle.sv
// laser_in_circle: combinational test of one point against a radius-R circle (full-width squares).
module laser_in_circle
  import laser_pkg::*;
(
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  output logic          hit
);
  logic [CW-1:0] dx, dy;
  logic [2*CW-1:0] sx, sy;
  logic [2*CW:0] d2;
  always_comb begin
    dx = px > cx ? px - cx : cx - px;
    dy = py > cy ? py - cy : cy - py;
    sx = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    sy = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    d2 = {1'b0, sx} + {1'b0, sy};
    hit = d2 <= (2*CW+1)'(R2);
  end
endmodule

// File: rtl/laser_cover_scorer.sv
// laser_cover_scorer: stores a frame of points, latches both centres on DONE rising, counts union coverage.
module laser_cover_scorer
  import laser_pkg::*;
(
  input logic clk,
  input logic rst,
  laser_cover_scorer_if.slave bus
);
  state_t state_q, state_d;
  logic [IW-1:0] pt_cnt_q, pt_cnt_d, eval_idx_q, eval_idx_d, waddr;
  logic [SW-1:0] score_q, score_d, hit1_q, hit1_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, rise, we, h1, h2;
  logic [CW-1:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
  logic [2*CW-1:0] pts_q [NPTS];
  logic [2*CW-1:0] pt;

  assign rise = bus.done & ~done_q;
  assign pt = pts_q[eval_idx_q];

  laser_in_circle u_c1 (.px(pt[2*CW-1:CW]), .py(pt[CW-1:0]), .cx(c1x_q), .cy(c1y_q), .hit(h1));
  laser_in_circle u_c2 (.px(pt[2*CW-1:CW]), .py(pt[CW-1:0]), .cx(c2x_q), .cy(c2y_q), .hit(h2));

  always_comb begin
    state_d = state_q;
    pt_cnt_d = pt_cnt_q;
    eval_idx_d = eval_idx_q;
    score_d = score_q;
    hit1_d = hit1_q;
    valid_d = 1'b0;
    c1x_d = c1x_q;
    c1y_d = c1y_q;
    c2x_d = c2x_q;
    c2y_d = c2y_q;
    we = 1'b0;
    waddr = state_q == IDLE ? '0 : pt_cnt_q;
    case (state_q)
      IDLE: if (bus.pt_valid) begin
        we = 1'b1;
        pt_cnt_d = IW'(1);
        state_d = LOAD;
      end
      LOAD: if (bus.pt_valid) begin
        we = 1'b1;
        pt_cnt_d = pt_cnt_q + IW'(1);
        state_d = pt_cnt_q == IW'(NPTS - 1) ? WAIT : LOAD;
      end
      WAIT: if (rise) begin
        {c1x_d, c1y_d, c2x_d, c2y_d} = {bus.c1x, bus.c1y, bus.c2x, bus.c2y};
        score_d = '0;
        hit1_d = '0;
        eval_idx_d = '0;
        state_d = EVAL;
      end
      EVAL: begin
        score_d = score_q + {{(SW-1){1'b0}}, h1 | h2};
        hit1_d = hit1_q + {{(SW-1){1'b0}}, h1};
        eval_idx_d = eval_idx_q + IW'(1);
        valid_d = eval_idx_q == IW'(NPTS - 1);
        state_d = valid_d ? REPORT : EVAL;
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {LOAD, WAIT, EVAL};
  end

  // done_q resets high so a DONE already asserted out of reset is not taken as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pt_cnt_q <= '0;
      eval_idx_q <= '0;
      score_q <= '0;
      hit1_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b1;
      {c1x_q, c1y_q, c2x_q, c2y_q} <= '0;
    end else begin
      state_q <= state_d;
      pt_cnt_q <= pt_cnt_d;
      eval_idx_q <= eval_idx_d;
      score_q <= score_d;
      hit1_q <= hit1_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= bus.done;
      {c1x_q, c1y_q, c2x_q, c2y_q} <= {c1x_d, c1y_d, c2x_d, c2y_d};
    end
  end

  always_ff @(posedge clk) if (we) pts_q[waddr] <= {bus.x, bus.y};

  assign bus.score = score_q;
  assign bus.hit1 = hit1_q;
  assign bus.score_valid = valid_q;
  assign bus.busy = busy_q;
endmodule
